// File: rtl/axi_lite_responder.sv
// ---------------------------------------------------------------------------
// axi_lite_responder
//   AXI4-Lite slave backed by a DEPTH x 32-bit register file. Write and read
//   paths are independent FSMs and never stall each other.
//
//   Handshake rule (all five channels): a transfer happens on a rising clk
//   edge where valid && ready are both 1. A source that raises valid holds it
//   and its payload stable until that edge. This block never withdraws
//   bvalid/rvalid or changes bresp/rresp/rdata before the handshake.
//
//   Parameters
//     DEPTH        number of 32-bit words (power of two, 2..256)
//     READ_LATENCY idle cycles in R_WAIT between AR handshake and rvalid (0..15)
//
//   Optional feature
//     AXI_LITE_RESPONDER_OOR_ERR_EN  when defined, addresses >= DEPTH*4 get
//     SLVERR, no write and rdata=0. Otherwise upper address bits alias.
//
//   Ports
//     clk, s_areset                    clock, async active-high reset
//     s_axi_aw* / s_axi_w* / s_axi_b*  write address / data / response
//     s_axi_ar* / s_axi_r*             read address / data
//     dbg_wr_state                     write FSM state (0 W_IDLE, 1 W_RESP)
//     dbg_rd_state                     read FSM state (0 R_IDLE, 1 R_WAIT, 2 R_DATA)
// ---------------------------------------------------------------------------
module axi_lite_responder #(
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        s_areset,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        dbg_wr_state,
  output logic [1:0]  dbg_rd_state
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] LAT_LOAD    = 4'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_t;

  logic [31:0] mem [DEPTH];

  // Ready outputs stay low during reset and come up on the first edge after
  // release; this flag provides that one-edge delay.
  logic ready_en;

  always_ff @(posedge clk or posedge s_areset) begin
    if (s_areset) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // -------------------------------------------------------------------------
  // Write path
  // -------------------------------------------------------------------------
  w_state_t    w_state, w_state_next;
  logic        aw_held, w_held;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_fire, w_fire, aw_have, w_have, commit;
  logic [31:0] cur_addr, cur_data;
  logic [3:0]  cur_strb;
  logic [IW-1:0] wr_idx;
  logic        wr_err;

  assign s_axi_awready = ready_en && (w_state == W_IDLE) && !aw_held;
  assign s_axi_wready  = ready_en && (w_state == W_IDLE) && !w_held;
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign dbg_wr_state  = w_state;

  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid && s_axi_wready;
  // "have" = captured earlier or being captured on this edge, so the write
  // commits on the very edge the second half arrives.
  assign aw_have = aw_held || aw_fire;
  assign w_have  = w_held || w_fire;
  assign commit  = (w_state == W_IDLE) && aw_have && w_have;

  assign cur_addr = aw_held ? aw_addr_q : s_axi_awaddr;
  assign cur_data = w_held  ? w_data_q  : s_axi_wdata;
  assign cur_strb = w_held  ? w_strb_q  : s_axi_wstrb;
  assign wr_idx   = cur_addr[IW+1:2];

`ifdef AXI_LITE_RESPONDER_OOR_ERR_EN
  assign wr_err = |cur_addr[31:IW+2];
`else
  assign wr_err = 1'b0;
`endif

  always_comb begin
    w_state_next = w_state;
    case (w_state)
      W_IDLE:  if (commit) w_state_next = W_RESP;
      W_RESP:  if (s_axi_bready) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge s_areset) begin
    if (s_areset) begin
      w_state     <= W_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      s_axi_bresp <= RESP_OKAY;
    end else begin
      w_state <= w_state_next;
      if (aw_fire) aw_addr_q <= s_axi_awaddr;
      if (w_fire) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (commit) begin
        aw_held     <= 1'b0;
        w_held      <= 1'b0;
        s_axi_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else begin
        if (aw_fire) aw_held <= 1'b1;
        if (w_fire)  w_held  <= 1'b1;
      end
    end
  end

  // Storage. Reads in the read path see the pre-edge value when a write to
  // the same word commits on the same edge (plain non-blocking semantics).
  always_ff @(posedge clk or posedge s_areset) begin
    if (s_areset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && !wr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_strb[b]) mem[wr_idx][8*b +: 8] <= cur_data[8*b +: 8];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read path
  // -------------------------------------------------------------------------
  r_state_t    r_state, r_state_next;
  logic [31:0] ar_addr_q;
  logic [3:0]  lat_cnt;
  logic        ar_fire, enter_data, rd_err;
  logic [31:0] sample_addr;
  logic [IW-1:0] rd_idx;

  assign s_axi_arready = ready_en && (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_DATA);
  assign dbg_rd_state  = r_state;
  assign ar_fire       = s_axi_arvalid && s_axi_arready;

  // With zero latency the sample happens on the AR handshake edge itself, so
  // the live address is used; otherwise the captured one.
  assign sample_addr = (r_state == R_IDLE) ? s_axi_araddr : ar_addr_q;
  assign rd_idx      = sample_addr[IW+1:2];
  assign enter_data  = (r_state_next == R_DATA) && (r_state != R_DATA);

`ifdef AXI_LITE_RESPONDER_OOR_ERR_EN
  assign rd_err = |sample_addr[31:IW+2];
`else
  assign rd_err = 1'b0;
`endif

  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE: begin
        if (ar_fire) r_state_next = (READ_LATENCY == 0) ? R_DATA : R_WAIT;
      end
      R_WAIT: begin
        if (lat_cnt == 4'd0) r_state_next = R_DATA;
      end
      R_DATA: begin
        if (s_axi_rready) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge s_areset) begin
    if (s_areset) begin
      r_state     <= R_IDLE;
      ar_addr_q   <= '0;
      lat_cnt     <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else begin
      r_state <= r_state_next;
      if (ar_fire) begin
        ar_addr_q <= s_axi_araddr;
        lat_cnt   <= LAT_LOAD;
      end else if (r_state == R_WAIT && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (enter_data) begin
        s_axi_rdata <= rd_err ? 32'h0 : mem[rd_idx];
        s_axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Size fields and byte-offset bits carry no meaning for word storage.
`ifdef AXI_LITE_RESPONDER_OOR_ERR_EN
  logic unused_bits;
  assign unused_bits = ^{s_axi_awsize, s_axi_arsize, cur_addr[1:0], sample_addr[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{s_axi_awsize, s_axi_arsize, cur_addr[1:0], sample_addr[1:0],
                         cur_addr[31:IW+2], sample_addr[31:IW+2]};
`endif

endmodule

// File: tb/tb_axi_lite_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_responder
//   Directed bench for axi_lite_responder at default parameters. Inputs are
//   driven 1 ns after each rising edge and outputs are sampled at that same
//   point, before new drives take effect on the next edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_responder;

  logic        clk = 1'b0;
  logic        s_areset = 1'b1;
  logic [31:0] s_axi_awaddr = '0;
  logic [2:0]  s_axi_awsize = 3'd2;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [31:0] s_axi_araddr = '0;
  logic [2:0]  s_axi_arsize = 3'd2;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;
  logic        dbg_wr_state;
  logic [1:0]  dbg_rd_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  axi_lite_responder dut (
    .clk(clk), .s_areset(s_areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awsize(s_axi_awsize),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arsize(s_axi_arsize),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: full write, both channels presented together
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, pa, pw;
    int n;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      pa = s_axi_awvalid && s_axi_awready;
      pw = s_axi_wvalid && s_axi_wready;
      tick();
      if (pa) begin s_axi_awvalid = 1'b0; aw_done = 1; end
      if (pw) begin s_axi_wvalid = 1'b0; w_done = 1; end
      n++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin tick(); n++; end
    chk("wr_bvalid_seen", 32'(s_axi_bvalid), 32'd1);
    resp = s_axi_bresp;
    tick();
  endtask

  // driver: full read; lat counts cycles from the AR handshake cycle to rvalid
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int n;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin tick(); n++; end
    tick();
    s_axi_arvalid = 1'b0;
    lat = 1;
    while (!s_axi_rvalid && lat < 40) begin tick(); lat++; end
    chk("rd_rvalid_seen", 32'(s_axi_rvalid), 32'd1);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    tick();
  endtask

  // scoreboard: expected read data queued before the read, popped on return
  task automatic rd_check(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0] r;
    int lat;
    exp_q.push_back(exp_data);
    do_read(addr, d, r, lat);
    chk({tag, "_rdata"}, d, exp_q.pop_front());
    chk({tag, "_rresp"}, 32'(r), 32'(exp_resp));
  endtask

  task automatic wr_check(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] r;
    do_write(addr, data, strb, r);
    chk({tag, "_bresp"}, 32'(r), 32'(exp_resp));
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int lat, n;
    bit got_r;
    logic [31:0] got_data;

    // --- reset state ---
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_wready",  32'(s_axi_wready),  32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
    chk("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
    chk("rst_rdata",   s_axi_rdata,        32'd0);
    s_areset = 1'b0;
    #1;
    chk("rel_awready_before_edge", 32'(s_axi_awready), 32'd0);
    tick();
    chk("rel_awready", 32'(s_axi_awready), 32'd1);
    chk("rel_wready",  32'(s_axi_wready),  32'd1);
    chk("rel_arready", 32'(s_axi_arready), 32'd1);

    // --- basic write then read, latency ---
    wr_check("w04", 32'h04, 32'hDEADBEEF, 4'hF, 2'b00);
    exp_q.push_back(32'hDEADBEEF);
    do_read(32'h04, d, r, lat);
    chk("r04_rdata", d, exp_q.pop_front());
    chk("r04_rresp", 32'(r), 32'd0);
    chk("r04_latency", 32'(lat), 32'd3);

    // --- W five cycles ahead of AW ---
    s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    chk("wfirst_wready_drop", 32'(s_axi_wready), 32'd0);
    chk("wfirst_awready_up", 32'(s_axi_awready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wfirst_no_bvalid", 32'(s_axi_bvalid), 32'd0);
    end
    s_axi_awaddr = 32'h08; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    chk("wfirst_bvalid", 32'(s_axi_bvalid), 32'd1);
    chk("wfirst_bresp", 32'(s_axi_bresp), 32'd0);
    chk("wfirst_dbg_state", 32'(dbg_wr_state), 32'd1);
    tick();
    chk("wfirst_bvalid_done", 32'(s_axi_bvalid), 32'd0);
    rd_check("r08", 32'h08, 32'h12345678, 2'b00);

    // --- byte strobes ---
    wr_check("w0c_full", 32'h0C, 32'hFFFFFFFF, 4'hF, 2'b00);
    wr_check("w0c_lane2", 32'h0C, 32'h00AA0000, 4'b0100, 2'b00);
    rd_check("r0c_lane2", 32'h0C, 32'hFFAAFFFF, 2'b00);
    wr_check("w0c_nostrb", 32'h0C, 32'h11111111, 4'b0000, 2'b00);
    rd_check("r0c_nostrb", 32'h0C, 32'hFFAAFFFF, 2'b00);
    rd_check("r0e_offset", 32'h0E, 32'hFFAAFFFF, 2'b00);

    // --- bready held low, concurrent read ---
    s_axi_bready = 1'b0;
    s_axi_awaddr = 32'h10; s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_araddr = 32'h04; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    got_r = 0; got_data = '0;
    for (int i = 0; i < 10; i++) begin
      chk("hold_bvalid",  32'(s_axi_bvalid),  32'd1);
      chk("hold_bresp",   32'(s_axi_bresp),   32'd0);
      chk("hold_awready", 32'(s_axi_awready), 32'd0);
      chk("hold_wready",  32'(s_axi_wready),  32'd0);
      if (s_axi_rvalid && !got_r) begin got_r = 1; got_data = s_axi_rdata; end
      tick();
      if (i == 0) s_axi_arvalid = 1'b0;
    end
    chk("hold_read_done", 32'(got_r), 32'd1);
    chk("hold_read_data", got_data, 32'hDEADBEEF);
    s_axi_bready = 1'b1;
    tick();
    chk("hold_release_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("hold_release_awready", 32'(s_axi_awready), 32'd1);
    rd_check("r10", 32'h10, 32'hCAFEF00D, 2'b00);

    // --- out-of-range address ---
    wr_check("w00", 32'h00, 32'h0BADF00D, 4'hF, 2'b00);
`ifdef AXI_LITE_RESPONDER_OOR_ERR_EN
    wr_check("w100", 32'h100, 32'h55AA55AA, 4'hF, 2'b10);
    rd_check("r100", 32'h100, 32'h0, 2'b10);
    rd_check("r00_after_oor", 32'h00, 32'h0BADF00D, 2'b00);
`else
    wr_check("w100", 32'h100, 32'h55AA55AA, 4'hF, 2'b00);
    rd_check("r100", 32'h100, 32'h55AA55AA, 2'b00);
    rd_check("r00_after_oor", 32'h00, 32'h55AA55AA, 2'b00);
`endif

    // --- write commit on the read sample edge returns old data ---
    wr_check("w14_old", 32'h14, 32'h01010101, 4'hF, 2'b00);
    s_axi_araddr = 32'h14; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    tick();
    s_axi_arvalid = 1'b0;
    tick();
    s_axi_awaddr = 32'h14; s_axi_wdata = 32'h02020202; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("coll_rvalid", 32'(s_axi_rvalid), 32'd1);
    chk("coll_rdata_old", s_axi_rdata, 32'h01010101);
    chk("coll_bvalid", 32'(s_axi_bvalid), 32'd1);
    s_axi_rready = 1'b1;
    tick();
    rd_check("r14_new", 32'h14, 32'h02020202, 2'b00);

    // --- reset in the middle of both responses ---
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    s_axi_awaddr = 32'h18; s_axi_wdata = 32'h77777777; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_araddr = 32'h04; s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin tick(); n++; end
    chk("mid_rvalid_before", 32'(s_axi_rvalid), 32'd1);
    chk("mid_bvalid_before", 32'(s_axi_bvalid), 32'd1);
    #1;
    s_areset = 1'b1;
    #1;
    chk("mid_rvalid_async", 32'(s_axi_rvalid), 32'd0);
    chk("mid_bvalid_async", 32'(s_axi_bvalid), 32'd0);
    chk("mid_rdata_async",  s_axi_rdata,       32'd0);
    chk("mid_arready_async", 32'(s_axi_arready), 32'd0);
    tick();
    tick();
    s_areset = 1'b0;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    tick();
    chk("mid_awready_after", 32'(s_axi_awready), 32'd1);
    rd_check("r04_after_rst", 32'h04, 32'h0, 2'b00);
    rd_check("r18_after_rst", 32'h18, 32'h0, 2'b00);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // overall time limit
  initial begin
    #200000;
    tests_run++;
    tests_failed++;
    $display("FAIL timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_lite_responder.md
AXI_LITE_RESPONDER -- requirements
Module: axi_lite_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of 32-bit storage words (power of two, 2..256).
REQ-002 The block SHALL have parameter READ_LATENCY, default 2, meaning idle cycles between the AR handshake and RVALID assertion (0..15).
REQ-003 The block SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port s_areset  in  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have ports s_axi_awaddr in 32, s_axi_awsize in 3, s_axi_awvalid in 1, s_axi_awready out 1  write address channel.
REQ-006 The block SHALL have ports s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1, s_axi_wready out 1  write data channel.
REQ-007 The block SHALL have ports s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1  write response channel.
REQ-008 The block SHALL have ports s_axi_araddr in 32, s_axi_arsize in 3, s_axi_arvalid in 1, s_axi_arready out 1  read address channel.
REQ-009 The block SHALL have ports s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1  read data channel.

Function
REQ-010 Word index SHALL be addr[log2(DEPTH)+1:2]; addr[1:0] ignored; awsize/arsize accepted and ignored.
REQ-011 Write FSM SHALL have states W_IDLE, W_RESP; in W_IDLE awready=1 until AW captured, wready=1 until W captured, each independently, in any order or same cycle.
REQ-012 Once both AW and W are held, the write SHALL commit on that clock edge (byte lane n written iff wstrb[n]) and the FSM SHALL enter W_RESP with bvalid=1 the following cycle.
REQ-013 In W_RESP awready=wready=0; bvalid and bresp SHALL hold stable until bvalid&&bready, then return to W_IDLE with awready=wready=1 the next cycle.
REQ-014 wstrb=4'b0000 SHALL complete with bresp=OKAY and no storage change.
REQ-015 Read FSM SHALL have states R_IDLE, R_WAIT, R_DATA; arready=1 only in R_IDLE; AR handshake captures address.
REQ-016 After the AR handshake the FSM SHALL spend READ_LATENCY cycles in R_WAIT (skipped when 0), then assert rvalid; minimum arvalid-to-rvalid latency is READ_LATENCY+1 cycles.
REQ-017 rdata SHALL be sampled from storage on the edge entering R_DATA and held with rresp stable until rvalid&&rready, then R_IDLE.
REQ-018 A write committing on the same edge that a read samples the same word SHALL yield the old data to the read.
REQ-019 Read and write FSMs SHALL operate concurrently with no mutual blocking.
REQ-020 OKAY=2'b00, SLVERR=2'b10; no other response codes SHALL be produced.

Reset
REQ-021 s_areset asserted SHALL immediately force W_IDLE, R_IDLE, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, awready=0, wready=0, arready=0.
REQ-022 awready, wready, arready SHALL rise on the first clk edge after s_areset deasserts.
REQ-023 Storage contents SHALL be cleared to 0 on reset; reset mid-transaction SHALL abandon it with no partial write.

Configuration
REQ-024 Macro AXI_LITE_RESPONDER_OOR_ERR_EN defined: accesses with addr >= DEPTH*4 SHALL return SLVERR, perform no write, and return rdata=32'h0.
REQ-025 Macro undefined: upper address bits SHALL be ignored (aliasing), every response OKAY.

Verification
REQ-026 Write 32'hDEADBEEF to 0x04, wstrb=4'hF, then read 0x04 -> bresp=OKAY, rdata=32'hDEADBEEF, rresp=OKAY, rvalid 3 cycles after AR handshake edge at default latency.
REQ-027 W presented 5 cycles before AW (addr 0x08, data 32'h12345678) -> wready drops after W handshake, bvalid rises 1 cycle after AW handshake, read 0x08 returns 32'h12345678.
REQ-028 Word 0x0C=32'hFFFFFFFF, write 32'h00AA0000 with wstrb=4'b0100 -> read returns 32'hFFAAFFFF.
REQ-029 bready held low 10 cycles -> bvalid/bresp stable, awready=wready=0 throughout; concurrent read completes unaffected.
REQ-030 Write/read addr 0x100 with DEPTH=16: macro defined -> bresp=rresp=2'b10, rdata=0, word 0 unchanged; undefined -> aliases word 0, OKAY.
REQ-031 s_areset asserted while rvalid=1 and during W_RESP -> rvalid, bvalid drop without waiting for clk; after release, read 0x04 returns 32'h0.
